// File: rtl/ram64_pkg.sv
// Shared constants and FSM state encoding for the RAM64 read-side stream initiator.
package ram64_pkg;

    localparam int unsigned RAM64_DATA_W = 16;
    localparam int unsigned RAM64_ADDR_W = 6;
    localparam int unsigned RAM64_DEPTH  = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StHold   = 2'd2,
        StFinish = 2'd3
    } state_e;

endpackage

// File: rtl/ram64.sv
// RAM64 memory block: synchronous write on load, combinational read from address.
module ram64 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out = mem_q[address];

endmodule

// File: rtl/ram64_addr_counter.sv
// Wrapping address register plus remaining-word down-counter for a RAM64 sweep.
module ram64_addr_counter #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int unsigned CntW  = ADDR_W + 1;
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    assign last_o = (cnt_q == CntW'(1));
    assign addr_o = addr_q;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = base_i;
            cnt_d  = (len_i > CntW'(Depth)) ? CntW'(Depth) : len_i;
        end else if (step_i) begin
            cnt_d = cnt_q - CntW'(1);
            // The final word leaves the address on the last location read.
            if (!last_o) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ram64_stream_reader.sv
// Sweeps a RAM64 address window and streams each word out on valid/ready.
// Optional XOR checksum output enabled by RAM64_STREAM_READER_CHECKSUM_EN.
module ram64_stream_reader
    import ram64_pkg::*;
#(
    parameter int unsigned DATA_W = RAM64_DATA_W,
    parameter int unsigned ADDR_W = RAM64_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_valid,
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic              data_ready
);

    state_e            state_q;
    logic              busy_q, done_q, valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic              cnt_load, cnt_step, cnt_last;
    logic              xfer;

    assign xfer     = (state_q == StHold) && valid_q && data_ready;
    assign cnt_load = (state_q == StIdle) && start && (length != '0);
    assign cnt_step = xfer;

    ram64_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (cnt_load),
        .step_i  (cnt_step),
        .base_i  (base_addr),
        .len_i   (length),
        .addr_o  (ram_address),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            data_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length != '0) begin
                            state_q <= StFetch;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    data_q      <= ram_out;
                    data_addr_q <= ram_address;
                    valid_q     <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        if (cnt_last) begin
                            state_q <= StFinish;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef RAM64_STREAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Cleared on any start taken in idle, including a zero-length one.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ data_q;
        end
    end

    assign checksum = csum_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign data_addr  = data_addr_q;
    assign data_valid = valid_q;
    assign ram_load   = 1'b0;
    assign ram_in     = '0;

endmodule

// File: tb/tb_ram64_stream_reader.sv
// Directed self-checking bench for ram64_stream_reader driving a real ram64 responder.
module tb_ram64_stream_reader;
    import ram64_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  length = '0;
    logic        busy, done, data_valid, ram_load;
    logic        data_ready = 1'b1;
    logic [5:0]  ram_address, data_addr;
    logic [15:0] ram_in, ram_out, data_out;
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic        preload = 1'b0;
    logic        pl_load = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [5:0]  mem_addr;
    logic [15:0] mem_in;
    logic        mem_load;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int side_err = 0;
    logic [15:0] xq_data [$];
    logic [5:0]  xq_addr [$];
    int          xq_cyc  [$];

    always #5 clk = ~clk;

    assign mem_addr = preload ? pl_addr : ram_address;
    assign mem_in   = preload ? pl_data : ram_in;
    assign mem_load = preload ? pl_load : ram_load;

    ram64 #(.DATA_W(16), .ADDR_W(6)) u_ram (
        .clk     (clk),
        .in      (mem_in),
        .load    (mem_load),
        .address (mem_addr),
        .out     (ram_out)
    );

    ram64_stream_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_load    (ram_load),
        .ram_in      (ram_in),
        .ram_out     (ram_out),
        .data_out    (data_out),
        .data_addr   (data_addr),
        .data_valid  (data_valid),
`ifdef RAM64_STREAM_READER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .data_ready  (data_ready)
    );

    // Pre-edge values are sampled here: the DUT updates with NBAs at the same edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (ram_load !== 1'b0 || ram_in !== 16'h0) side_err <= side_err + 1;
        if (data_valid && data_ready) begin
            xq_data.push_back(data_out);
            xq_addr.push_back(data_addr);
            xq_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        preload = 1'b1;
        pl_addr = a;
        pl_data = d;
        pl_load = 1'b1;
        @(negedge clk);
        pl_load = 1'b0;
        preload = 1'b0;
    endtask

    task automatic clear_log();
        xq_data.delete();
        xq_addr.delete();
        xq_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic pulse_start(input logic [5:0] b, input logic [6:0] l);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [5:0] b, input logic [6:0] l, input string tag);
        clear_log();
        pulse_start(b, l);
        wait_done(400, tag);
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] exp_d [4];
    logic [5:0]  exp_a [4];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_ram_address", 32'(ram_address), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_data_addr", 32'(data_addr), 32'd0);
        check_eq("rst_ram_load", 32'(ram_load), 32'd0);
        check_eq("rst_ram_in", 32'(ram_in), 32'd0);
        reset = 1'b0;

        // Basic sweep base=0 length=4
        poke(6'd0, 16'h0000);
        poke(6'd1, 16'hFFFF);
        poke(6'd2, 16'h00FF);
        poke(6'd3, 16'hFF00);
        side_err = 0;
        exp_d = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00};
        exp_a = '{6'd0, 6'd1, 6'd2, 6'd3};
        run_sweep(6'd0, 7'd4, "basic_timeout");
        check_eq("basic_count", 32'(xq_data.size()), 32'd4);
        for (int i = 0; i < xq_data.size() && i < 4; i++) begin
            check_eq($sformatf("basic_data%0d", i), 32'(xq_data[i]), 32'(exp_d[i]));
            check_eq($sformatf("basic_addr%0d", i), 32'(xq_addr[i]), 32'(exp_a[i]));
            if (i > 0) check_eq($sformatf("basic_rate%0d", i), 32'(xq_cyc[i] - xq_cyc[i-1]), 32'd2);
        end
        check_eq("basic_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("basic_ram_side", 32'(side_err), 32'd0);

        // Wrap base=62 length=4
        poke(6'd62, 16'h3333);
        poke(6'd63, 16'hCCCC);
        poke(6'd0, 16'h0F0F);
        poke(6'd1, 16'hF0F0);
        exp_d = '{16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};
        exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
        run_sweep(6'd62, 7'd4, "wrap_timeout");
        check_eq("wrap_count", 32'(xq_data.size()), 32'd4);
        for (int i = 0; i < xq_data.size() && i < 4; i++) begin
            check_eq($sformatf("wrap_data%0d", i), 32'(xq_data[i]), 32'(exp_d[i]));
            check_eq($sformatf("wrap_addr%0d", i), 32'(xq_addr[i]), 32'(exp_a[i]));
        end

        // Latency and backpressure: base=2 length=2, ready low for 5 cycles
        clear_log();
        data_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 6'd2;
        length = 7'd2;
        @(negedge clk);
        start = 1'b0;
        check_eq("lat_busy", 32'(busy), 32'd1);
        check_eq("lat_valid_early", 32'(data_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_valid", 32'(data_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_valid%0d", i), 32'(data_valid), 32'd1);
            check_eq($sformatf("bp_data%0d", i), 32'(data_out), 32'h00FF);
            check_eq($sformatf("bp_addr%0d", i), 32'(data_addr), 32'd2);
            check_eq($sformatf("bp_ram_addr%0d", i), 32'(ram_address), 32'd2);
            @(negedge clk);
        end
        data_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_after_valid", 32'(data_valid), 32'd0);
        check_eq("bp_after_ram_addr", 32'(ram_address), 32'd3);
        wait_done(50, "bp_timeout");
        check_eq("bp_count", 32'(xq_data.size()), 32'd2);
        repeat (2) @(negedge clk);

        // Zero length
        clear_log();
        @(negedge clk);
        start = 1'b1;
        base_addr = 6'd7;
        length = 7'd0;
        @(negedge clk);
        start = 1'b0;
        check_eq("len0_done", 32'(done), 32'd1);
        check_eq("len0_busy", 32'(busy), 32'd0);
        check_eq("len0_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        check_eq("len0_done_once", 32'(done), 32'd0);
        check_eq("len0_xfers", 32'(xq_data.size()), 32'd0);

        // Length 100 clamps to 64, ends at base-1
        run_sweep(6'd5, 7'd100, "len100_timeout");
        check_eq("len100_count", 32'(xq_data.size()), 32'd64);
        if (xq_addr.size() == 64) begin
            check_eq("len100_first", 32'(xq_addr[0]), 32'd5);
            check_eq("len100_last", 32'(xq_addr[63]), 32'd4);
        end
        check_eq("len100_final_ram_addr", 32'(ram_address), 32'd4);
        check_eq("len100_done_pulses", 32'(done_cnt), 32'd1);

        // Start during sweep is ignored
        clear_log();
        pulse_start(6'd0, 7'd4);
        repeat (2) @(negedge clk);
        start = 1'b1;
        base_addr = 6'd20;
        length = 7'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "mid_start_timeout");
        exp_a = '{6'd0, 6'd1, 6'd2, 6'd3};
        check_eq("mid_start_count", 32'(xq_addr.size()), 32'd4);
        for (int i = 0; i < xq_addr.size() && i < 4; i++) begin
            check_eq($sformatf("mid_start_addr%0d", i), 32'(xq_addr[i]), 32'(exp_a[i]));
        end
        repeat (3) @(negedge clk);
        check_eq("mid_start_no_restart", 32'(busy), 32'd0);

        // Reset in HOLD aborts silently
        clear_log();
        data_ready = 1'b0;
        pulse_start(6'd0, 7'd4);
        @(negedge clk);
        check_eq("rst_hold_valid_pre", 32'(data_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_hold_valid", 32'(data_valid), 32'd0);
        check_eq("rst_hold_busy", 32'(busy), 32'd0);
        check_eq("rst_hold_state", 32'(dut.state_q), 32'(StIdle));
        data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_hold_no_done", 32'(done_cnt), 32'd0);
        check_eq("rst_hold_no_xfer", 32'(xq_data.size()), 32'd0);

`ifdef RAM64_STREAM_READER_CHECKSUM_EN
        poke(6'd0, 16'h0F0F);
        poke(6'd1, 16'hF0F0);
        poke(6'd2, 16'h1234);
        poke(6'd3, 16'h0000);
        clear_log();
        pulse_start(6'd0, 7'd4);
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check_eq("csum_done", 32'(done), 32'd1);
        check_eq("csum_value", 32'(checksum), 32'hEDCB);
        repeat (3) @(negedge clk);
        check_eq("csum_stable", 32'(checksum), 32'hEDCB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram64_stream_reader.md
Name: ram64_stream_reader

Overview:
- Read-side initiator for the RAM64 memory block. Memory tests today only write into RAM64.
- On a start pulse, sweeps a contiguous address window of RAM64 with ram_load held low.
- Captures each word from RAM64's combinational out port and presents it on a valid/ready output stream.
- Sits between RAM64 and any consumer, such as a checker, display or copier.

Parameters:
- DATA_W, 16, RAM word width; must match RAM64.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.

Ports:
- clk  in  1  rising-edge clock, shared with RAM64.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- base_addr  in  ADDR_W  first address of the sweep; sampled with start.
- length  in  ADDR_W+1  number of words to read (0..127); sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at sweep end.
- ram_address  out  ADDR_W  drives RAM64 address.
- ram_load  out  1  drives RAM64 load; constant 0.
- ram_in  out  DATA_W  drives RAM64 in; constant 0.
- ram_out  in  DATA_W  RAM64 out, combinational from ram_address.
- data_out  out  DATA_W  captured word.
- data_addr  out  ADDR_W  address data_out was read from.
- data_valid  out  1  stream valid.
- data_ready  in  1  stream ready from the consumer.

Behaviour:
- Reset (synchronous, active-high, clk edge): state=IDLE. busy, done, data_valid = 0. ram_address, data_out, data_addr, internal count = 0. ram_load and ram_in are always 0.
- Reset asserted mid-sweep aborts the sweep. No done pulse is produced. An un-accepted data_valid is dropped.
- FSM states: IDLE, FETCH, HOLD, FINISH.
- IDLE:
  - start=1 and length!=0: latch ram_address<=base_addr. Latch count<=min(length,64); values 65..127 clamp to 64. Go to FETCH; busy=1.
  - start=1 and length=0: done=1 for one cycle; stay IDLE; busy stays 0.
- FETCH: ram_address has been stable for one cycle and ram_out is valid. At the edge: data_out<=ram_out, data_addr<=ram_address, data_valid<=1. Go to HOLD.
- HOLD: data_out and data_addr are held stable while data_valid=1 and data_ready=0. A transfer occurs on an edge with data_valid && data_ready. On transfer:
  - data_valid<=0 and count<=count-1.
  - If count==1, go to FINISH.
  - Otherwise ram_address<=ram_address+1, wrapping modulo 64 (63 -> 0), and go to FETCH.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE. A start in FINISH is ignored.
- Throughput: 2 cycles per word when data_ready is held high. Latency is start edge to first data_valid = 2 edges.
- start while busy is ignored. base_addr and length are not re-sampled mid-sweep.
- data_ready while data_valid=0 has no effect.
- Wrap: base=62, length=4 reads addresses 62, 63, 0, 1.
- Full-depth sweep: length=64 reads every word once and ends at base-1 (mod 64).

Optional Feature:
- Macro: RAM64_STREAM_READER_CHECKSUM_EN.
- When defined, adds output checksum [DATA_W-1:0]:
  - Cleared to 0 on reset and on each accepted start.
  - XOR-accumulates every transferred word.
  - Final value is stable from the done cycle until the next accepted start.
- When undefined, the port and register are absent. All other behaviour is identical.

Decomposition:
- Shared package ram64_pkg holds:
  - RAM64_DATA_W=16, RAM64_ADDR_W=6, RAM64_DEPTH=64.
  - The state encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, FINISH=2'd3.
- One natural sub-module: ram64_addr_counter. It holds the wrapping address register plus the remaining-word down-counter, and has load, step and last outputs.
- The FSM and output register stay in ram64_stream_reader.
- The bench instantiates the real RAM64 as the responder.

Test Plan:
- Preload RAM64 addr0=0x0000, 1=0xFFFF, 2=0x00FF, 3=0xFF00. Pulse start with base=0, length=4, data_ready=1. Required: stream 0x0000, 0xFFFF, 0x00FF, 0xFF00 with data_addr 0..3; 2 cycles/word; one done pulse; ram_load=0 throughout.
- Wrap: addr62=0x3333, 63=0xCCCC, 0=0x0F0F, 1=0xF0F0; base=62, length=4. Required: data_addr sequence 62, 63, 0, 1 with matching data.
- Backpressure: data_ready=0 for 5 cycles after the first valid. Required: data_out, data_addr and data_valid held stable; the next ram_address change happens only after the transfer.
- Edge lengths: length=0 gives done the next cycle with busy=0 and no data_valid. length=100 gives exactly 64 transfers.
- Start during sweep: pulse start (base=20) mid-sweep. Required: it is ignored and the original addresses continue. Assert reset mid-HOLD: the next cycle has data_valid=0, busy=0, state IDLE, and no done pulse.
- With RAM64_STREAM_READER_CHECKSUM_EN: sweep base=0, length=4 over data 0x0F0F, 0xF0F0, 0x1234, 0x0000. Required: checksum=0xEDCB at done.
